word_check: RTL and testbench
=============================

Name: word_check

Overview:
- Response analyser for the RAM BIST, receiving the read-back data of a BIST pass.
- Regenerates the same 4-word test pattern sequence the pattern generator drives during writes: 010, 111, 011, 100, repeating.
- Compares each read word against the expected word, counts mismatches, and captures the first failure.
- Reports pass/fail to the BIST controller at the end of the pass.

Parameters:
- Word_size, 3, RAM word width. Must be ≥3. Pattern words are zero-extended to Word_size.
- Addr_size, 4, width of the RAM address captured on failure.
- Cnt_size, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a check pass.
- start_idx  input  2  initial pattern index, loaded on start.
- data_valid  input  1  data_in/addr_in hold a read word this cycle.
- data_in  input  Word_size  word read from RAM.
- addr_in  input  Addr_size  address of data_in.
- last  input  1  qualifies data_valid beat as the final beat of the pass.
- busy  output  1  high while in RUN.
- done  output  1  high in DONE.
- pass  output  1  valid when done=1; 1 means zero mismatches.
- err_pulse  output  1  one-cycle pulse, registered, for each mismatching beat.
- err_count  output  Cnt_size  number of mismatches, saturating.
- fail_addr  output  Addr_size  addr_in of the first mismatch.
- fail_data  output  Word_size  data_in of the first mismatch.
- fail_exp  output  Word_size  expected word of the first mismatch.

Behaviour:

Reset:
- reset=1 at posedge: state=IDLE, idx=0, fail_seen=0.
- All outputs are 0: busy, done, pass, err_pulse, err_count, fail_addr, fail_data, fail_exp.
- reset overrides every other input, including mid-pass.

Expected word:
- exp = pattern[idx]. pattern[0]=010, [1]=111, [2]=011, [3]=100, zero-extended to Word_size.
- Comparison is full Word_size equality.

FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → RUN next cycle.
  - On entry to RUN: idx←start_idx; err_count, fail_seen, fail_* and pass are cleared; done←0; busy←1.
  - data_valid and last are ignored in IDLE.
- RUN:
  - Each cycle with data_valid=1 is one beat, compared against the current exp.
  - idx←idx+1 mod 4 after every beat (wraps 3→0).
  - On a mismatch:
    - err_pulse=1 in the next cycle.
    - err_count increments, saturating at 2^Cnt_size−1.
    - If fail_seen=0: capture addr_in, data_in, exp into fail_*, and set fail_seen.
  - Cycles with data_valid=0 change nothing; idx holds.
  - start is ignored in RUN.
  - data_valid=1 with last=1: that beat is compared normally, then the next state is DONE.
  - last without data_valid is ignored.
- DONE:
  - busy=0, done=1.
  - pass = (final err_count == 0), and includes the mismatch status of the last beat.
  - Outputs hold until start or reset.
  - start=1 → RUN with the same clearing as from IDLE; done drops in that cycle.

Latency:
- All outputs are registered.
- Beat in cycle N → err_pulse, err_count and fail_* are updated at cycle N+1.
- A last beat in cycle N → done=1 and pass are valid at cycle N+1.
- busy=0 at the same edge.

Boundary conditions:
- Saturated err_count stays at max; err_pulse still fires on each mismatch.
- Only the first failure is ever captured.
- A single-beat pass (first beat has last=1) is legal.

Test Plan:
1. reset, start with start_idx=0; 6 beats data_in=010,111,011,100,010,111 on addr 0..5, last on addr 5 → err_count=0, done=1 and pass=1 one cycle after the last beat, err_pulse never high.
2. start_idx=2; beats 011,100,010; beat 1 data_in=000 at addr 1 → err_pulse once, err_count=1, fail_addr=1, fail_data=000, fail_exp=100, pass=0.
3. Cnt_size=2; 5 beats all 000 from start_idx=0, with 2-cycle gaps of data_valid=0 → idx advances only on beats, err_count saturates at 3, fail_addr is the first beat's address, err_pulse fires 5 times.
4. Assert reset mid-RUN after 2 beats with one mismatch → all outputs 0, state IDLE; a following data_valid with last is ignored; done stays 0.
5. From DONE with pass=0, pulse start with start_idx=3; beat 100 with last → err_count cleared to 0, then done=1, pass=1.
6. start pulsed during RUN, and data_valid given in IDLE → no effect on idx, err_count or state.

Source files
------------

// File: rtl/word_check.sv
// Response analyser for the RAM BIST: compares read-back words against the repeating
// 4-word test pattern, counts mismatches and captures the first failure of a pass.
module word_check #(
  parameter int unsigned Word_size = 3,
  parameter int unsigned Addr_size = 4,
  parameter int unsigned Cnt_size  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           start_idx,
  input  logic                 data_valid,
  input  logic [Word_size-1:0] data_in,
  input  logic [Addr_size-1:0] addr_in,
  input  logic                 last,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 err_pulse,
  output logic [Cnt_size-1:0]  err_count,
  output logic [Addr_size-1:0] fail_addr,
  output logic [Word_size-1:0] fail_data,
  output logic [Word_size-1:0] fail_exp
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic                 fail_seen_q, fail_seen_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [Cnt_size-1:0]  err_count_q, err_count_d;
  logic [Addr_size-1:0] fail_addr_q, fail_addr_d;
  logic [Word_size-1:0] fail_data_q, fail_data_d;
  logic [Word_size-1:0] fail_exp_q, fail_exp_d;

  logic [Word_size-1:0] exp_word;
  logic                 mismatch;

  // Same sequence the pattern generator writes, zero-extended to the RAM width.
  always_comb begin
    exp_word = '0;
    unique case (idx_q)
      2'd0: exp_word[2:0] = 3'b010;
      2'd1: exp_word[2:0] = 3'b111;
      2'd2: exp_word[2:0] = 3'b011;
      2'd3: exp_word[2:0] = 3'b100;
      default: exp_word = '0;
    endcase
  end

  assign mismatch = data_valid && (data_in != exp_word);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fail_seen_d = fail_seen_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    fail_exp_d  = fail_exp_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StRun;
          idx_d       = start_idx;
          fail_seen_d = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_count_d = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          fail_exp_d  = '0;
        end
      end
      StRun: begin
        if (data_valid) begin
          idx_d = idx_q + 2'd1;
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + Cnt_size'(1);
            end
            if (!fail_seen_q) begin
              fail_seen_d = 1'b1;
              fail_addr_d = addr_in;
              fail_data_d = data_in;
              fail_exp_d  = exp_word;
            end
          end
          if (last) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // The final beat's own result must be folded in here.
            pass_d  = !mismatch && (err_count_q == '0);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= 2'd0;
      fail_seen_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_exp_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fail_seen_q <= fail_seen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      fail_exp_q  <= fail_exp_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign fail_exp  = fail_exp_q;

endmodule

// File: tb/tb_word_check.sv
// Bench for word_check: directed scenarios plus randomized passes checked against a
// per-pass model of the pattern sequence. A second instance uses a 2-bit counter.
module tb_word_check;

  localparam int unsigned WS  = 3;
  localparam int unsigned AS  = 4;
  localparam int unsigned CS  = 8;
  localparam int unsigned CSS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, data_valid, last;
  logic [1:0]    start_idx;
  logic [WS-1:0] data_in;
  logic [AS-1:0] addr_in;

  logic          busy, done, pass, err_pulse;
  logic [CS-1:0] err_count;
  logic [AS-1:0] fail_addr;
  logic [WS-1:0] fail_data, fail_exp;

  logic           busy_s, done_s, pass_s, err_pulse_s;
  logic [CSS-1:0] err_count_s;
  logic [AS-1:0]  fail_addr_s;
  logic [WS-1:0]  fail_data_s, fail_exp_s;

  word_check #(.Word_size(WS), .Addr_size(AS), .Cnt_size(CS)) dut (
    .clk(clk), .reset(reset), .start(start), .start_idx(start_idx),
    .data_valid(data_valid), .data_in(data_in), .addr_in(addr_in), .last(last),
    .busy(busy), .done(done), .pass(pass), .err_pulse(err_pulse), .err_count(err_count),
    .fail_addr(fail_addr), .fail_data(fail_data), .fail_exp(fail_exp)
  );

  word_check #(.Word_size(WS), .Addr_size(AS), .Cnt_size(CSS)) dut_s (
    .clk(clk), .reset(reset), .start(start), .start_idx(start_idx),
    .data_valid(data_valid), .data_in(data_in), .addr_in(addr_in), .last(last),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_pulse(err_pulse_s),
    .err_count(err_count_s), .fail_addr(fail_addr_s), .fail_data(fail_data_s),
    .fail_exp(fail_exp_s)
  );

  int checks = 0;
  int errors = 0;

  logic [WS-1:0] b_data [32];
  logic [AS-1:0] b_addr [32];
  int            b_gap  [32];
  logic          obs_pulse [32];
  logic          obs_pulse_s [32];
  int            stray;
  logic          obs_busy0, obs_done0;
  logic [CS-1:0] obs_cnt0;

  // Model results for one pass
  logic          m_mis [32];
  int            m_errs;
  int            m_first;

  function automatic logic [WS-1:0] pat(input int i);
    logic [WS-1:0] r;
    r = '0;
    case (i % 4)
      0: r[2:0] = 3'b010;
      1: r[2:0] = 3'b111;
      2: r[2:0] = 3'b011;
      default: r[2:0] = 3'b100;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_pass(input int sidx, input int n);
    m_errs  = 0;
    m_first = -1;
    for (int k = 0; k < n; k++) begin
      m_mis[k] = (b_data[k] != pat(sidx + k));
      if (m_mis[k]) begin
        if (m_first < 0) m_first = k;
        m_errs++;
      end
    end
  endtask

  task automatic run_pass(input int sidx, input int n);
    start     = 1'b1;
    start_idx = sidx[1:0];
    tick();
    start     = 1'b0;
    obs_busy0 = busy;
    obs_done0 = done;
    obs_cnt0  = err_count;
    stray     = 0;
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < b_gap[k]; g++) begin
        tick();
        if (err_pulse || err_pulse_s) stray++;
      end
      data_valid = 1'b1;
      data_in    = b_data[k];
      addr_in    = b_addr[k];
      last       = (k == n - 1);
      tick();
      obs_pulse[k]   = err_pulse;
      obs_pulse_s[k] = err_pulse_s;
      data_valid     = 1'b0;
      last           = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({busy, done, pass, err_pulse, err_count, fail_addr, fail_data, fail_exp} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b pass=%b pulse=%b cnt=%0d, expected all 0",
               busy, done, pass, err_pulse, err_count);
    end
    checks++;
    if ({busy_s, done_s, pass_s, err_pulse_s, err_count_s} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_small: got nonzero outputs, expected all 0");
    end
  endtask

  task automatic test_clean_pass();
    int np;
    for (int k = 0; k < 6; k++) begin
      b_data[k] = pat(k);
      b_addr[k] = AS'(k);
      b_gap[k]  = 0;
    end
    run_pass(0, 6);
    np = 0;
    for (int k = 0; k < 6; k++) np += int'(obs_pulse[k]);
    checks++;
    if (obs_busy0 !== 1'b1) begin
      errors++; $display("FAIL clean_busy: got %b expected 1", obs_busy0);
    end
    checks++;
    if (np + stray != 0) begin
      errors++; $display("FAIL clean_pulses: got %0d expected 0", np + stray);
    end
    checks++;
    if (err_count !== 0) begin
      errors++; $display("FAIL clean_count: got %0d expected 0", err_count);
    end
    checks++;
    if ({done, pass, busy} !== 3'b110) begin
      errors++; $display("FAIL clean_done_pass: got done=%b pass=%b busy=%b expected 1 1 0",
                         done, pass, busy);
    end
  endtask

  task automatic test_single_mismatch();
    b_data[0] = 3'b011; b_data[1] = 3'b000; b_data[2] = 3'b010;
    for (int k = 0; k < 3; k++) begin
      b_addr[k] = AS'(k);
      b_gap[k]  = 0;
    end
    run_pass(2, 3);
    checks++;
    if ({obs_pulse[0], obs_pulse[1], obs_pulse[2]} !== 3'b010) begin
      errors++; $display("FAIL single_pulses: got %b%b%b expected 010",
                         obs_pulse[0], obs_pulse[1], obs_pulse[2]);
    end
    checks++;
    if (err_count !== 1) begin
      errors++; $display("FAIL single_count: got %0d expected 1", err_count);
    end
    checks++;
    if ({fail_addr, fail_data, fail_exp} !== {4'd1, 3'b000, 3'b100}) begin
      errors++; $display("FAIL single_capture: got addr=%0d data=%b exp=%b expected 1 000 100",
                         fail_addr, fail_data, fail_exp);
    end
    checks++;
    if ({done, pass} !== 2'b10) begin
      errors++; $display("FAIL single_pass: got done=%b pass=%b expected 1 0", done, pass);
    end
  endtask

  task automatic test_restart_from_done();
    b_data[0] = 3'b100;
    b_addr[0] = 4'd9;
    b_gap[0]  = 0;
    run_pass(3, 1);
    checks++;
    if ({obs_done0, obs_busy0, obs_cnt0} !== {1'b0, 1'b1, 8'd0}) begin
      errors++; $display("FAIL restart_clear: got done=%b busy=%b cnt=%0d expected 0 1 0",
                         obs_done0, obs_busy0, obs_cnt0);
    end
    checks++;
    if ({done, pass, err_count, fail_addr} !== {1'b1, 1'b1, 8'd0, 4'd0}) begin
      errors++; $display("FAIL restart_result: got done=%b pass=%b cnt=%0d faddr=%0d expected 1 1 0 0",
                         done, pass, err_count, fail_addr);
    end
  endtask

  task automatic test_saturation();
    int np_s;
    for (int k = 0; k < 5; k++) begin
      b_data[k] = '0;
      b_addr[k] = AS'(k + 3);
      b_gap[k]  = 2;
    end
    run_pass(0, 5);
    np_s = 0;
    for (int k = 0; k < 5; k++) np_s += int'(obs_pulse_s[k]);
    checks++;
    if (err_count_s !== 2'd3) begin
      errors++; $display("FAIL sat_count: got %0d expected 3", err_count_s);
    end
    checks++;
    if (err_count !== 8'd5) begin
      errors++; $display("FAIL sat_wide_count: got %0d expected 5", err_count);
    end
    checks++;
    if (np_s != 5 || stray != 0) begin
      errors++; $display("FAIL sat_pulses: got %0d (stray %0d) expected 5 (stray 0)", np_s, stray);
    end
    checks++;
    if ({fail_addr_s, fail_exp_s} !== {4'd3, 3'b010}) begin
      errors++; $display("FAIL sat_first: got addr=%0d exp=%b expected 3 010",
                         fail_addr_s, fail_exp_s);
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; start_idx = 2'd0; tick(); start = 1'b0;
    data_valid = 1'b1; data_in = 3'b010; addr_in = 4'd0; tick();
    data_in = 3'b000; addr_in = 4'd1; tick();
    data_valid = 1'b0;
    checks++;
    if (err_pulse !== 1'b1) begin
      errors++; $display("FAIL midrun_pulse: got %b expected 1", err_pulse);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if ({busy, done, pass, err_pulse, err_count, fail_addr, fail_data, fail_exp} !== '0) begin
      errors++; $display("FAIL midrun_reset: got busy=%b done=%b cnt=%0d faddr=%0d expected all 0",
                         busy, done, err_count, fail_addr);
    end
    data_valid = 1'b1; last = 1'b1; data_in = 3'b101; tick();
    data_valid = 1'b0; last = 1'b0;
    checks++;
    if ({busy, done, err_pulse, err_count} !== '0) begin
      errors++; $display("FAIL idle_last_ignored: got busy=%b done=%b pulse=%b cnt=%0d expected 0",
                         busy, done, err_pulse, err_count);
    end
  endtask

  task automatic test_ignored_inputs();
    for (int i = 0; i < 3; i++) begin
      data_valid = 1'b1; data_in = 3'b000; last = i[0]; tick();
    end
    data_valid = 1'b0; last = 1'b0;
    checks++;
    if ({busy, done, err_pulse, err_count} !== '0) begin
      errors++; $display("FAIL idle_beats_ignored: got busy=%b done=%b cnt=%0d expected 0",
                         busy, done, err_count);
    end
    start = 1'b1; start_idx = 2'd0; tick(); start = 1'b0;
    data_valid = 1'b1; data_in = 3'b010; addr_in = 4'd0; tick();
    data_valid = 1'b0;
    start = 1'b1; start_idx = 2'd2; tick(); start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++; $display("FAIL run_start_ignored: got busy=%b done=%b expected 1 0", busy, done);
    end
    data_valid = 1'b1; data_in = 3'b111; addr_in = 4'd1; last = 1'b1; tick();
    data_valid = 1'b0; last = 1'b0;
    checks++;
    if ({done, pass, err_count} !== {1'b1, 1'b1, 8'd0}) begin
      errors++; $display("FAIL run_start_idx_kept: got done=%b pass=%b cnt=%0d expected 1 1 0",
                         done, pass, err_count);
    end
  endtask

  task automatic test_random();
    int sidx, n, sat_exp;
    for (int p = 0; p < 25; p++) begin
      sidx = $urandom_range(0, 3);
      n    = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        b_data[k] = ($urandom_range(0, 2) == 0) ? WS'($urandom) : pat(sidx + k);
        b_addr[k] = AS'($urandom);
        b_gap[k]  = $urandom_range(0, 2);
      end
      model_pass(sidx, n);
      run_pass(sidx, n);
      sat_exp = (m_errs > 3) ? 3 : m_errs;
      for (int k = 0; k < n; k++) begin
        checks++;
        if (obs_pulse[k] !== m_mis[k] || obs_pulse_s[k] !== m_mis[k]) begin
          errors++; $display("FAIL rand_pulse[%0d.%0d]: got %b/%b expected %b",
                             p, k, obs_pulse[k], obs_pulse_s[k], m_mis[k]);
        end
      end
      checks++;
      if (err_count !== CS'(m_errs) || err_count_s !== CSS'(sat_exp) || stray != 0) begin
        errors++; $display("FAIL rand_count[%0d]: got %0d/%0d stray %0d expected %0d/%0d stray 0",
                           p, err_count, err_count_s, stray, m_errs, sat_exp);
      end
      checks++;
      if ({done, busy, pass} !== {1'b1, 1'b0, m_errs == 0}) begin
        errors++; $display("FAIL rand_status[%0d]: got done=%b busy=%b pass=%b expected 1 0 %b",
                           p, done, busy, pass, m_errs == 0);
      end
      checks++;
      if (m_first >= 0) begin
        if ({fail_addr, fail_data, fail_exp} !==
            {b_addr[m_first], b_data[m_first], pat(sidx + m_first)}) begin
          errors++; $display("FAIL rand_capture[%0d]: got %0d %b %b expected %0d %b %b", p,
                             fail_addr, fail_data, fail_exp, b_addr[m_first], b_data[m_first],
                             pat(sidx + m_first));
        end
      end else if ({fail_addr, fail_data, fail_exp} !== '0) begin
        errors++; $display("FAIL rand_capture[%0d]: got %0d %b %b expected 0 0 0", p,
                           fail_addr, fail_data, fail_exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_idx = 2'd0; data_valid = 1'b0;
    data_in = '0; addr_in = '0; last = 1'b0;
    test_reset();
    test_clean_pass();
    test_single_mismatch();
    test_restart_from_done();
    test_saturation();
    test_reset_mid_run();
    test_ignored_inputs();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
